// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller:
//   - access request codes carried on mem_read / mem_write
//   - controller FSM state encoding
//   - small decode helpers used by the controller
// -----------------------------------------------------------------------------
package dmem_pkg;

   // Request codes (same encoding for read and write)
   localparam logic [1:0] ACC_NONE = 2'b00;
   localparam logic [1:0] ACC_BYTE = 2'b01;
   localparam logic [1:0] ACC_RSVD = 2'b10;
   localparam logic [1:0] ACC_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // A code requests an access only when it is BYTE or WORD; RSVD behaves as NONE.
   function automatic logic code_valid(input logic [1:0] code);
      logic v;
      case (code)
         ACC_BYTE, ACC_WORD: v = 1'b1;
         ACC_NONE, ACC_RSVD: v = 1'b0;
         default:            v = 1'b0;
      endcase
      return v;
   endfunction

   // Byte-enable pattern: all lanes for a word, one little-endian lane for a byte.
   function automatic logic [3:0] lane_mask(input logic is_word, input logic [1:0] lane);
      logic [3:0] m;
      if (is_word) begin
         m = 4'hF;
      end else begin
         m = 4'b0001 << lane;
      end
      return m;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// Storage is deliberately not reset.
// Ports:
//   clk      in   clock
//   en_i     in   port enable (read and/or write this edge)
//   we_i     in   write enable (qualified by en_i)
//   be_i     in   4-bit byte enable, bit n covers bits [8n+7:8n]
//   idx_i    in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data (pre-write contents on a write cycle)
// -----------------------------------------------------------------------------
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Read-first port: byte-lane writes and the registered read share one edge
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) begin
                  mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
               end
            end
         end
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Four-phase request/response controller in front of a byte-addressable
// 32-bit data memory. A request is accepted in IDLE, waits WAIT_CYCLES
// cycles, answers with a one-cycle ready pulse in RESP, then sits in DONE
// until both request codes return to 00.
//
// Configuration macro: DMEM_ERR_CHECK_EN
//   defined   -> err port present; misaligned word access, read+write
//                collision, or out-of-range address bits raise err with
//                ready, and a flagged write is suppressed.
//   undefined -> no err port; addresses wrap, word accesses align down and
//                a read+write collision performs only the read.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mem_read   in   read request code  (00 none, 01 byte, 11 word, 10 reserved)
//   mem_write  in   write request code (same encoding)
//   addr       in   byte address
//   wdata      in   write data (byte write uses wdata[7:0])
//   rdata      out  read data, nonzero only during the ready cycle
//   ready      out  one-cycle response pulse
//   busy       out  high whenever the FSM is not IDLE
//   err        out  error flag valid with ready (macro builds only)
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy
`ifdef DMEM_ERR_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Latched access
   logic             rd_q;
   logic             word_q;
   logic             flag_q;
   logic [1:0]       lane_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;

   logic ready_q;
   logic busy_q;

   // Incoming request decode
   logic             rd_v_s;
   logic             wr_v_s;
   logic             req_s;
   logic             in_word_s;
   logic             in_flag_s;
   logic             hi_nz_s;
   logic [IDX_W-1:0] in_idx_s;

   // Access presented to the RAM (live inputs in IDLE, latched copy afterwards)
   logic             cur_rd_s;
   logic             cur_word_s;
   logic             cur_flag_s;
   logic [1:0]       cur_lane_s;
   logic [IDX_W-1:0] cur_idx_s;
   logic [31:0]      cur_wdata_s;

   logic        go_resp_s;
   logic        ram_en_s;
   logic        ram_we_s;
   logic [3:0]  ram_be_s;
   logic [31:0] ram_wdata_s;
   logic [31:0] ram_rdata_s;
   logic [31:0] rdata_s;

   assign rd_v_s    = code_valid(mem_read);
   assign wr_v_s    = code_valid(mem_write);
   assign req_s     = rd_v_s | wr_v_s;
   // A collision performs the read, so the read code decides the width
   assign in_word_s = rd_v_s ? (mem_read == ACC_WORD) : (mem_write == ACC_WORD);
   assign in_idx_s  = addr[IDX_W+1:2];
   assign hi_nz_s   = ((addr >> (IDX_W + 2)) != 32'd0);

`ifdef DMEM_ERR_CHECK_EN
   assign in_flag_s = (in_word_s && (addr[1:0] != 2'b00)) || (rd_v_s && wr_v_s) || hi_nz_s;
`else
   logic unused_hi_s;
   assign in_flag_s   = 1'b0;
   assign unused_hi_s = hi_nz_s;
`endif

   // Select live or latched access; with WAIT_CYCLES=0 the RAM is hit on the accepting edge
   always_comb begin
      cur_rd_s    = rd_q;
      cur_word_s  = word_q;
      cur_flag_s  = flag_q;
      cur_lane_s  = lane_q;
      cur_idx_s   = idx_q;
      cur_wdata_s = wdata_q;
      if (state_q == ST_IDLE) begin
         cur_rd_s    = rd_v_s;
         cur_word_s  = in_word_s;
         cur_flag_s  = in_flag_s;
         cur_lane_s  = addr[1:0];
         cur_idx_s   = in_idx_s;
         cur_wdata_s = wdata;
      end else begin
         cur_rd_s    = rd_q;
         cur_word_s  = word_q;
         cur_flag_s  = flag_q;
         cur_lane_s  = lane_q;
         cur_idx_s   = idx_q;
         cur_wdata_s = wdata_q;
      end
   end

   // Next-state logic and wait-state counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // Four-phase handshake: only an all-zero request releases DONE
            if ((mem_read == ACC_NONE) && (mem_write == ACC_NONE)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // The RAM is touched only on the edge that enters RESP; gating with rst_n
   // keeps a request held during reset from writing while the FSM is forced idle.
   assign go_resp_s   = (state_d == ST_RESP) && (state_q != ST_RESP);
   assign ram_en_s    = go_resp_s & rst_n;
   assign ram_we_s    = ram_en_s & ~cur_rd_s & ~cur_flag_s;
   assign ram_be_s    = lane_mask(cur_word_s, cur_lane_s);
   assign ram_wdata_s = cur_word_s ? cur_wdata_s : {4{cur_wdata_s[7:0]}};

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .en_i    (ram_en_s),
      .we_i    (ram_we_s),
      .be_i    (ram_be_s),
      .idx_i   (cur_idx_s),
      .wdata_i (ram_wdata_s),
      .rdata_o (ram_rdata_s)
   );

   // FSM state, counter and response flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == ST_RESP);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Capture the access at the accepting edge; later input changes are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= 1'b0;
         word_q  <= 1'b0;
         flag_q  <= 1'b0;
         lane_q  <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'd0;
      end else if ((state_q == ST_IDLE) && req_s) begin
         rd_q    <= rd_v_s;
         word_q  <= in_word_s;
         flag_q  <= in_flag_s;
         lane_q  <= addr[1:0];
         idx_q   <= in_idx_s;
         wdata_q <= wdata;
      end
   end

   // Read data is driven only during RESP: word as-is, byte zero-extended
   always_comb begin
      rdata_s = 32'd0;
      if ((state_q == ST_RESP) && rd_q) begin
         if (word_q) begin
            rdata_s = ram_rdata_s;
         end else begin
            rdata_s = {24'd0, ram_rdata_s[{lane_q, 3'b000} +: 8]};
         end
      end else begin
         rdata_s = 32'd0;
      end
   end

   assign rdata = rdata_s;
   assign ready = ready_q;
   assign busy  = busy_q;

`ifdef DMEM_ERR_CHECK_EN
   logic err_q;

   // Error flag accompanies the ready pulse only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state_d == ST_RESP) ? cur_flag_s : 1'b0;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit storage words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the wait-state count between acceptance and response (range 0-15).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mem_read  in  2  read request code: 00 none, 01 byte, 11 word, 10 reserved.
REQ-006 mem_write  in  2  write request code, same encoding as mem_read.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  write data; a byte write uses wdata[7:0].
REQ-009 rdata  out  32  read data, valid only while ready=1.
REQ-010 ready  out  1  one-cycle response pulse.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 err  out  1  error flag, valid with ready; present only under the configuration macro.

Function
REQ-013 The FSM SHALL have four states: IDLE, WAIT, RESP, DONE.
REQ-014 IDLE: the block SHALL accept a request when mem_read or mem_write is 01 or 11, latching the code, addr and wdata at that edge.
REQ-015 The block SHALL treat code 10 as no request.
REQ-016 After acceptance, the FSM SHALL go to WAIT for WAIT_CYCLES cycles, then to RESP; with WAIT_CYCLES=0 it SHALL go straight to RESP.
REQ-017 ready SHALL be high only in RESP, exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-018 RESP SHALL last one cycle, then the FSM SHALL go to DONE.
REQ-019 DONE SHALL hold until mem_read and mem_write are both 00 (four-phase handshake), then the FSM SHALL return to IDLE; a request held high SHALL never be re-executed.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the array size.
REQ-021 Byte lanes SHALL be little-endian: lane addr[1:0]=0 is bits [7:0].
REQ-022 A byte read SHALL return the selected lane zero-extended to 32 bits.
REQ-023 A byte write SHALL modify only the selected lane.
REQ-024 A word access SHALL ignore addr[1:0], i.e. align down.
REQ-025 Writes SHALL commit on the edge entering RESP.
REQ-026 Read data SHALL be captured on the same edge and held stable for the RESP cycle.
REQ-027 If read and write are both requested, only the read SHALL be performed and no write SHALL occur.
REQ-028 Outside RESP, rdata SHALL be 0.
REQ-029 Input changes during WAIT, RESP and DONE SHALL NOT affect the latched access.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, ready=0, busy=0, rdata=0 and err=0.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 A reset during WAIT SHALL abort the access, and no write SHALL commit.
REQ-033 After reset release, a request already held high SHALL be accepted on the first clock edge.

Configuration
REQ-034 The macro DMEM_ERR_CHECK_EN SHALL control error checking and the err port.
REQ-035 With DMEM_ERR_CHECK_EN defined, err SHALL equal 1 with ready for any of: a word access with addr[1:0]!=0, simultaneous read+write, or address bits above the array range being nonzero.
REQ-036 With DMEM_ERR_CHECK_EN defined, a flagged write SHALL NOT commit.
REQ-037 Without DMEM_ERR_CHECK_EN, the err port SHALL be absent and behaviour SHALL follow REQ-020, REQ-024 and REQ-027 silently.

Structure
REQ-038 Package dmem_pkg SHALL hold the access-code constants (NONE, BYTE, WORD, RSVD) and the FSM state typedef.
REQ-039 Sub-module dmem_array SHALL be a single-port synchronous RAM with a 4-bit byte-enable and a write-enable; the controller SHALL hold all FSM and lane logic.

Verification
REQ-040 Word write, WAIT_CYCLES=1: write 11, addr 0x10, wdata 0xDEADBEEF -> ready 2 cycles after acceptance; then word read 0x10 -> rdata 0xDEADBEEF.
REQ-041 Byte write 01, addr 0x12, wdata 0x000000A5 onto word 0x11223344 -> word read 0x10 returns 0x11A53344; byte read 0x12 returns 0x000000A5.
REQ-042 Held request: mem_read=11 held for 6 cycles -> exactly one ready pulse; a new ready pulse only after inputs return to 00 and the request is re-asserted.
REQ-043 Reset during WAIT of write 0xCAFEF00D to 0x20 -> ready never pulses; a later read of 0x20 returns the prior value.
REQ-044 With DMEM_ERR_CHECK_EN: word write to 0x22 -> ready=1, err=1, memory unchanged; simultaneous read/write -> err=1, read data correct.
REQ-045 WAIT_CYCLES=0, DEPTH_WORDS=1024: write 0x55 byte to addr 0x1000 -> read at 0x0 lane 0 returns 0x55 (wrap-around), ready 1 cycle after acceptance.
